// File: rtl/inv_bank_filt.sv
// Bank of N independent debounced channels: synchronizer chain, per-channel
// level filter with FILT_LEN qualification, bypass mode and per-bit output polarity.
module inv_bank_filt #(
  parameter int unsigned N           = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] inv_mask,
  input  logic         bypass,
  output logic [N-1:0] y,
  output logic [N-1:0] chg
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  sync_d [SYNC_STAGES];
  logic [N-1:0]  state_q, state_d;
  logic [N-1:0]  chg_q, chg_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic          bypass_q, bypass_d;
  logic          mode_chg;
  logic [N-1:0]  sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign mode_chg  = bypass ^ bypass_q;

  always_comb begin
    sync_d[0] = a;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    bypass_d = bypass;
    state_d  = state_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (bypass) begin
        state_d[i] = sync_last[i];
      end else if (sync_last[i] != state_q[i]) begin
        // On a mode-change edge the count is treated as already cleared.
        if (mode_chg ? (CNT_LAST == '0) : (cnt_q[i] == CNT_LAST)) begin
          state_d[i] = sync_last[i];
        end else if (!mode_chg) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    chg_d = state_d ^ state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      state_q  <= '0;
      chg_q    <= '0;
      bypass_q <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q  <= state_d;
      chg_q    <= chg_d;
      bypass_q <= bypass_d;
    end
  end

  assign y   = state_q ^ inv_mask;
  assign chg = chg_q;

endmodule

// File: tb/tb_inv_bank_filt.sv
// Directed checks of inv_bank_filt: default build plus N=1/FILT_LEN=255
// and N=32/FILT_LEN=1 builds sharing clock and reset.
module tb_inv_bank_filt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  a = '0, inv_mask = '0, y, chg;
  logic        bypass = 1'b0;
  logic [0:0]  la = '0, ly, lchg;
  logic [31:0] wa = '0, wmask = '0, wy, wchg;
  logic        wbypass = 1'b0;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  inv_bank_filt #(.N(6), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .inv_mask(inv_mask), .bypass(bypass),
    .y(y), .chg(chg));

  inv_bank_filt #(.N(1), .SYNC_STAGES(2), .FILT_LEN(255)) dut_long (
    .clk(clk), .rst_n(rst_n), .a(la), .inv_mask(1'b0), .bypass(1'b0),
    .y(ly), .chg(lchg));

  inv_bank_filt #(.N(32), .SYNC_STAGES(2), .FILT_LEN(1)) dut_wide (
    .clk(clk), .rst_n(rst_n), .a(wa), .inv_mask(wmask), .bypass(wbypass),
    .y(wy), .chg(wchg));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int unsigned seen;
  int unsigned pulses;

  initial begin
    // basic rise, mask 0
    #1;
    chk("rst_y", 32'(y), 32'(inv_mask));
    chk("rst_chg", 32'(chg), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    a = 6'h01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("rise_y_e%0d", k), 32'(y), (k >= 6) ? 32'h01 : 32'h00);
      chk($sformatf("rise_chg_e%0d", k), 32'(chg), (k == 6) ? 32'h01 : 32'h00);
    end

    // full inversion, async reset, two channels together
    inv_mask = 6'h3F;
    rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'h3F);
    chk("arst_chg", 32'(chg), 0);
    tick();
    rst_n = 1'b1;
    a = 6'h03;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("inv_y_e%0d", k), 32'(y), (k >= 6) ? 32'h3C : 32'h3F);
      chk($sformatf("inv_chg_e%0d", k), 32'(chg), (k == 6) ? 32'h03 : 32'h00);
    end
    inv_mask = 6'h00;
    #1;
    chk("mask_y_comb", 32'(y), 32'h03);
    chk("mask_chg_kept", 32'(chg), 32'h03);
    tick();
    chk("mask_chg_drop", 32'(chg), 0);

    // 3-cycle glitch rejected
    a = 6'h07;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) a = 6'h03;
      chk($sformatf("gl3_y_e%0d", k), 32'(y), 32'h03);
      chk($sformatf("gl3_chg_e%0d", k), 32'(chg), 0);
    end
    // 4-cycle pulse accepted both ways
    a = 6'h07;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) a = 6'h03;
      chk($sformatf("gl4_y_e%0d", k), 32'(y), (k >= 6 && k <= 9) ? 32'h07 : 32'h03);
      chk($sformatf("gl4_chg_e%0d", k), 32'(chg), (k == 6 || k == 10) ? 32'h04 : 32'h00);
    end

    // bypass latency
    a = 6'h00;
    do_reset();
    tick();
    tick();
    bypass = 1'b1;
    a = 6'h02;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("byp_y_e%0d", k), 32'(y), (k >= 3) ? 32'h02 : 32'h00);
      chk($sformatf("byp_chg_e%0d", k), 32'(chg), (k == 3) ? 32'h02 : 32'h00);
    end
    // bypass pulse in the middle of a filter count
    bypass = 1'b0;
    a = 6'h00;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("mid_hold_e%0d", k), 32'(y), 32'h02);
    end
    bypass = 1'b1;
    tick();
    chk("mid_byp_y", 32'(y), 32'h00);
    chk("mid_byp_chg", 32'(chg), 32'h02);
    bypass = 1'b0;
    tick();
    chk("mid_chg_off", 32'(chg), 0);
    a = 6'h02;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("refil_y_e%0d", k), 32'(y), (k >= 6) ? 32'h02 : 32'h00);
    end

    // reset mid-count discards progress
    a = 6'h0A;
    for (int k = 1; k <= 4; k++) tick();
    chk("pre_rst_y", 32'(y), 32'h02);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", 32'(y), 0);
    chk("mid_rst_chg", 32'(chg), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("rel_y_e%0d", k), 32'(y), (k >= 6) ? 32'h0A : 32'h00);
      chk($sformatf("rel_chg_e%0d", k), 32'(chg), (k == 6) ? 32'h0A : 32'h00);
    end

    // N=32, FILT_LEN=1 matches bypass latency
    wa = 32'hA5A5_0001;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("w_y_e%0d", k), wy, (k >= 3) ? 32'hA5A5_0001 : 32'h0);
      chk($sformatf("w_chg_e%0d", k), wchg, (k == 3) ? 32'hA5A5_0001 : 32'h0);
    end
    wbypass = 1'b1;
    wa = 32'h0000_FFFF;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("wb_y_e%0d", k), wy, (k >= 3) ? 32'h0000_FFFF : 32'hA5A5_0001);
      chk($sformatf("wb_chg_e%0d", k), wchg, (k == 3) ? 32'hA5A5_FFFE : 32'h0);
    end
    wmask = 32'hFFFF_FFFF;
    #1;
    chk("w_mask", wy, 32'hFFFF_0000);

    // N=1, FILT_LEN=255: 254-cycle pulse rejected, 255 accepted
    seen = 0;
    la = 1'b1;
    for (int k = 1; k <= 264; k++) begin
      tick();
      if (k == 254) la = 1'b0;
      if (ly[0] || lchg[0]) seen++;
    end
    chk("long_rej254", seen, 0);
    la = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 520; k++) begin
      tick();
      if (k == 255) la = 1'b0;
      if (lchg[0]) pulses++;
      if (k == 256) chk("long_e256", 32'(ly), 0);
      if (k == 257) begin
        chk("long_e257_y", 32'(ly), 1);
        chk("long_e257_chg", 32'(lchg), 1);
      end
      if (k == 258) chk("long_e258_chg", 32'(lchg), 0);
      if (k == 511) chk("long_e511", 32'(ly), 1);
      if (k == 512) chk("long_e512", 32'(ly), 0);
    end
    chk("long_pulses", pulses, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inv_bank_filt.md
INV_BANK_FILT -- requirements
Module: inv_bank_filt

Interface
REQ-001 Parameter N, default 6: number of independent channels; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth per channel; legal range 2..4.
REQ-003 Parameter FILT_LEN, default 4: consecutive cycles an input must hold a new level before acceptance; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 a  input  N  asynchronous channel inputs, one bit per channel.
REQ-007 inv_mask  input  N  per-channel output polarity, quasi-static: 1 = inverting, 0 = buffering.
REQ-008 bypass  input  1  quasi-static mode select: 1 = filter disabled.
REQ-009 y  output  N  channel outputs, y[i] = state[i] XOR inv_mask[i], combinational from registered state.
REQ-010 chg  output  N  registered one-cycle pulse per channel on each accepted level change.

Function
REQ-011 Each channel shall pass a[i] through SYNC_STAGES flops; sync[i] denotes the last stage.
REQ-012 Each channel shall hold a filtered bit state[i] and a counter cnt[i] of width clog2(FILT_LEN+1).
REQ-013 Filter mode (bypass=0), per edge: sync[i]==state[i] -> cnt[i]<=0.
REQ-014 Filter mode, per edge: sync[i]!=state[i] and cnt[i]<FILT_LEN-1 -> cnt[i]<=cnt[i]+1, state[i] held.
REQ-015 Filter mode, per edge: sync[i]!=state[i] and cnt[i]==FILT_LEN-1 -> state[i]<=sync[i], cnt[i]<=0.
REQ-016 An input glitch shorter than FILT_LEN post-sync cycles shall never change state[i]; any return to agreement shall clear cnt[i].
REQ-017 Latency: a[i] changing and held stable -> state[i] flips at the (SYNC_STAGES+FILT_LEN)th rising edge after the change; defaults give 6.
REQ-018 Bypass mode (bypass=1): state[i]<=sync[i] every edge, cnt[i] held 0; latency SYNC_STAGES+1 edges (3 at defaults).
REQ-019 Any bypass transition shall clear all cnt[i] on that edge; no partial count carries across a mode change.
REQ-020 FILT_LEN=1 shall behave cycle-identically to bypass mode.
REQ-021 chg[i] shall be 1 during exactly the cycle in which the new state[i] first appears, and 0 otherwise.
REQ-022 Channels shall be fully independent; simultaneous changes on any subset shall each follow REQ-013..021 with no interaction.
REQ-023 inv_mask changes shall affect y immediately (combinationally), shall not alter state, cnt or chg, and shall not raise chg.
REQ-024 The counter shall never exceed FILT_LEN-1 and shall never wrap.

Reset
REQ-025 rst_n low shall immediately clear all sync flops, state, cnt and chg to 0, independent of clk.
REQ-026 During and just after reset, y shall equal inv_mask and chg shall be all zero.
REQ-027 Reset asserted mid-count shall discard the partial count; a level already at a[i] at release re-qualifies from zero (full REQ-017 latency).
REQ-028 Reset release shall be synchronous to the design's use; the first state update occurs on the first rising edge with rst_n high.

Verification
REQ-029 Defaults, inv_mask=6'b000000, a[0] 0->1 held -> y[0] rises at edge 6, chg[0]=1 for that one cycle only, y[5:1]=0.
REQ-030 Defaults, inv_mask=6'b111111, reset -> y=6'b111111; a=6'b000011 held -> y=6'b111100 at edge 6.
REQ-031 Defaults, a[2] pulse high 3 cycles then low -> y[2] and chg[2] never change; a 4-cycle post-sync pulse -> y[2] toggles once each way.
REQ-032 bypass=1, a[1] 0->1 -> y[1] rises at edge 3 with chg[1] pulse; toggle bypass mid-count in filter mode -> count restarts from 0.
REQ-033 rst_n low after 2 counted cycles with a[3]=1, then released -> y[3] rises only 6 edges after release, chg[3] single pulse.
REQ-034 N=1 and N=32, FILT_LEN=1 and FILT_LEN=255 builds: latency matches REQ-017/REQ-020 exactly; 254-cycle pulse rejected, 255-cycle pulse accepted.
